// File: rtl/pool_out_pingpong_buf_cxy.sv
// Ping-pong frame buffer that sits behind the 2x2 max-pooling core and replays each frame over valid/ready.
// Optional macro POOL_BUF_RELU_EN clamps negative pixels to zero on the write path.
module pool_out_pingpong_buf_cxy #(
    parameter int P_WIDTH     = 32,
    parameter int P_HEIGHT    = 32,
    parameter int P_PIX_CNT_W = 10,
    parameter int DW          = 24
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic signed [DW-1:0] DIN,
    input  logic                 DIN_VALID,
    input  logic                 DIN_LAST_IN_LINE,
    input  logic                 DIN_LAST_PIX,
    output logic signed [DW-1:0] OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_LAST_IN_LINE,
    output logic                 OUT_LAST_PIX,
    output logic                 DRAIN_DONE,
    output logic                 OVERFLOW,
    output logic                 FRAME_ERR
);
    localparam int N     = P_WIDTH * P_HEIGHT;
    localparam int LEN_W = P_PIX_CNT_W + 1;
    localparam int COL_W = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;

    localparam logic [P_PIX_CNT_W-1:0] CNT_LAST = P_PIX_CNT_W'(N - 1);
    localparam logic [COL_W-1:0]       COL_LAST = COL_W'(P_WIDTH - 1);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_DRAINING
    } bank_st_t;

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] d);
`ifdef POOL_BUF_RELU_EN
        relu = d[DW-1] ? '0 : d;
`else
        relu = d;
`endif
    endfunction

    bank_st_t                bank_st [2];
    logic [LEN_W-1:0]        rd_len  [2];
    logic signed [DW-1:0]    mem     [2][N];

    logic                    wr_bank;
    logic [P_PIX_CNT_W-1:0]  wr_cnt;
    logic                    rd_bank;
    logic [LEN_W-1:0]        rd_cnt;
    logic [COL_W-1:0]        col;

    // Line markers are rebuilt from the column counter, so the incoming one is not needed.
    logic unused_line_marker;
    assign unused_line_marker = DIN_LAST_IN_LINE;

    logic wr_open, wr_acc, wr_close, frame_ok;
    logic xfer, rd_avail, rd_load, rd_last, rd_done;
    logic signed [DW-1:0] rd_word;

    assign wr_open  = (bank_st[wr_bank] == B_EMPTY) || (bank_st[wr_bank] == B_FILLING);
    assign wr_acc   = DIN_VALID && wr_open;
    assign wr_close = wr_acc && (DIN_LAST_PIX || (wr_cnt == CNT_LAST));
    assign frame_ok = DIN_LAST_PIX && (wr_cnt == CNT_LAST);

    assign xfer     = OUT_VALID && OUT_READY;
    assign rd_avail = (bank_st[rd_bank] == B_FULL) ||
                      ((bank_st[rd_bank] == B_DRAINING) && (rd_cnt != rd_len[rd_bank]));
    assign rd_load  = rd_avail && (!OUT_VALID || xfer);
    assign rd_last  = (rd_cnt == (rd_len[rd_bank] - 1'b1));
    assign rd_done  = xfer && OUT_LAST_PIX;
    assign rd_word  = mem[rd_bank][rd_cnt[P_PIX_CNT_W-1:0]];

    // Write stage: pixel lands in the bank at the DIN_VALID edge.
    always_ff @(posedge CLK) begin
        if (RSTn && wr_acc) begin
            mem[wr_bank][wr_cnt] <= relu(DIN);
        end
    end

    // Bank bookkeeping and output register; reader and writer never touch the same bank in a cycle.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            bank_st[0]       <= B_EMPTY;
            bank_st[1]       <= B_EMPTY;
            rd_len[0]        <= '0;
            rd_len[1]        <= '0;
            wr_bank          <= 1'b0;
            wr_cnt           <= '0;
            rd_bank          <= 1'b0;
            rd_cnt           <= '0;
            col              <= '0;
            OUT_DATA         <= '0;
            OUT_VALID        <= 1'b0;
            OUT_LAST_IN_LINE <= 1'b0;
            OUT_LAST_PIX     <= 1'b0;
            DRAIN_DONE       <= 1'b0;
            OVERFLOW         <= 1'b0;
            FRAME_ERR        <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (wr_close) begin
                    bank_st[wr_bank] <= B_FULL;
                    rd_len[wr_bank]  <= {1'b0, wr_cnt} + LEN_W'(1);
                    wr_cnt           <= '0;
                    wr_bank          <= ~wr_bank;
                    if (!frame_ok) begin
                        FRAME_ERR <= 1'b1;
                    end
                end else begin
                    bank_st[wr_bank] <= B_FILLING;
                    wr_cnt           <= wr_cnt + 1'b1;
                end
            end else if (DIN_VALID) begin
                OVERFLOW <= 1'b1;
            end

            // Output stage
            if (rd_load) begin
                OUT_DATA         <= rd_word;
                OUT_VALID        <= 1'b1;
                OUT_LAST_IN_LINE <= (col == COL_LAST);
                OUT_LAST_PIX     <= rd_last;
                bank_st[rd_bank] <= B_DRAINING;
                rd_cnt           <= rd_cnt + 1'b1;
                col              <= (rd_last || (col == COL_LAST)) ? '0 : col + 1'b1;
            end else if (xfer) begin
                OUT_VALID <= 1'b0;
            end

            if (rd_done) begin
                bank_st[rd_bank] <= B_EMPTY;
                rd_cnt           <= '0;
                rd_bank          <= ~rd_bank;
            end
            DRAIN_DONE <= rd_done;
        end
    end
endmodule

// File: tb/tb_pool_out_pingpong_buf_cxy.sv
// Bench for pool_out_pingpong_buf_cxy: frame-level queue model plus directed scenarios on a 2x2 frame.
module tb_pool_out_pingpong_buf_cxy;
    localparam int W  = 2;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic          DIN_VALID = 1'b0;
    logic          DIN_LAST_IN_LINE = 1'b0;
    logic          DIN_LAST_PIX = 1'b0;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID, OUT_LAST_IN_LINE, OUT_LAST_PIX, DRAIN_DONE, OVERFLOW, FRAME_ERR;

    pool_out_pingpong_buf_cxy #(
        .P_WIDTH(W), .P_HEIGHT(H), .P_PIX_CNT_W(2), .DW(DW)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_LAST_IN_LINE(DIN_LAST_IN_LINE), .DIN_LAST_PIX(DIN_LAST_PIX),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_LAST_IN_LINE(OUT_LAST_IN_LINE), .OUT_LAST_PIX(OUT_LAST_PIX),
        .DRAIN_DONE(DRAIN_DONE), .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] v);
`ifdef POOL_BUF_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    typedef struct packed {
        logic [DW-1:0] d;
        logic          lil;
        logic          lp;
    } px_t;

    // Model: completed frames become an expected pixel stream; at most two frames occupy banks.
    px_t           exp_q[$];
    px_t           log_q[$];
    logic [DW-1:0] cur[$];
    logic [DW-1:0] ref_q[$];
    int            busy = 0;
    logic          m_ovf = 1'b0, m_ferr = 1'b0, exp_drain = 1'b0, prev_stall = 1'b0;
    px_t           prev_px;
    int            drain_cnt = 0;

    always @(negedge CLK) begin
        px_t e, a, p;
        if (!RSTn) begin
            exp_q.delete();
            cur.delete();
            busy       = 0;
            m_ovf      = 1'b0;
            m_ferr     = 1'b0;
            exp_drain  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("overflow_flag", OVERFLOW, m_ovf);
            check("frame_err_flag", FRAME_ERR, m_ferr);
            check("drain_done", DRAIN_DONE, exp_drain);
            if (DRAIN_DONE) drain_cnt++;
            if (prev_stall) begin
                check("stall_valid", OUT_VALID, 1);
                check("stall_data", OUT_DATA, prev_px.d);
                check("stall_lil", OUT_LAST_IN_LINE, prev_px.lil);
                check("stall_lp", OUT_LAST_PIX, prev_px.lp);
            end
            if (DIN_VALID) begin
                if (cur.size() > 0 || busy < 2) begin
                    cur.push_back(relu_m(DIN));
                    if (DIN_LAST_PIX || cur.size() == N) begin
                        if (!(DIN_LAST_PIX && cur.size() == N)) m_ferr = 1'b1;
                        for (int i = 0; i < cur.size(); i++) begin
                            p.d   = cur[i];
                            p.lil = ((i % W) == W - 1);
                            p.lp  = (i == cur.size() - 1);
                            exp_q.push_back(p);
                        end
                        busy++;
                        cur.delete();
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
            exp_drain = 1'b0;
            if (OUT_VALID) check("valid_has_pixel", int'(exp_q.size() > 0), 1);
            if (OUT_VALID && OUT_READY && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("xfer_data", OUT_DATA, e.d);
                check("xfer_lil", OUT_LAST_IN_LINE, e.lil);
                check("xfer_lp", OUT_LAST_PIX, e.lp);
                a.d = OUT_DATA; a.lil = OUT_LAST_IN_LINE; a.lp = OUT_LAST_PIX;
                log_q.push_back(a);
                if (e.lp) begin
                    busy--;
                    exp_drain = 1'b1;
                end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_px.d = OUT_DATA; prev_px.lil = OUT_LAST_IN_LINE; prev_px.lp = OUT_LAST_PIX;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v, input logic last, input logic lil);
        DIN = v; DIN_VALID = 1'b1; DIN_LAST_PIX = last; DIN_LAST_IN_LINE = lil;
        tick;
        DIN_VALID = 1'b0; DIN_LAST_PIX = 1'b0; DIN_LAST_IN_LINE = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int n, input logic with_last);
        for (int i = 0; i < n; i++)
            send(base + DW'(i), with_last && (i == n - 1), (i % W) == W - 1);
    endtask

    task automatic do_reset;
        RSTn = 1'b0;
        tick;
        RSTn = 1'b1;
        log_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || OUT_VALID) && k < 100) begin
            tick;
            k++;
        end
        check({name, "_timeout"}, int'(k < 100), 1);
        tick;
        tick;
    endtask

    // Literal replay check against ref_q; markers follow a frame of flen pixels, width 2.
    task automatic check_log(input string name, input int flen);
        check({name, "_len"}, log_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < log_q.size(); i++) begin
            check({name, "_d"}, log_q[i].d, ref_q[i]);
            check({name, "_lil"}, log_q[i].lil, int'(((i % flen) % 2) == 1));
            check({name, "_lp"}, log_q[i].lp, int'((i % flen) == flen - 1));
        end
        log_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        int d0;
        RSTn = 1'b0;
        tick;
        tick;
        RSTn = 1'b1;
        @(negedge CLK);
        check("rst_valid", OUT_VALID, 0);
        check("rst_data", OUT_DATA, 0);
        check("rst_lil", OUT_LAST_IN_LINE, 0);
        check("rst_lp", OUT_LAST_PIX, 0);
        check("rst_drain", DRAIN_DONE, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_ferr", FRAME_ERR, 0);
        tick;

        // Basic frame, latency and drain pulse
        OUT_READY = 1'b1;
        log_q.delete();
        d0 = drain_cnt;
        send(8'd1, 1'b0, 1'b0);
        send(8'd2, 1'b0, 1'b1);
        send(8'd3, 1'b0, 1'b0);
        send(8'd4, 1'b1, 1'b1);
        @(negedge CLK);
        check("t1_lat_lo", OUT_VALID, 0);
        @(negedge CLK);
        check("t1_lat_hi", OUT_VALID, 1);
        check("t1_first", OUT_DATA, 1);
        wait_idle("t1");
        ref_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        check_log("t1", 4);
        check("t1_drain_cnt", drain_cnt - d0, 1);

        // Three frames with the consumer stalled: third one is dropped
        OUT_READY = 1'b0;
        send_frame(8'd10, 4, 1'b1);
        send_frame(8'd20, 4, 1'b1);
        send_frame(8'd30, 4, 1'b1);
        tick;
        @(negedge CLK);
        check("t2_overflow", OVERFLOW, 1);
        check("t2_hold_valid", OUT_VALID, 1);
        check("t2_hold_data", OUT_DATA, 10);
        tick;
        OUT_READY = 1'b1;
        wait_idle("t2");
        ref_q = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd20, 8'd21, 8'd22, 8'd23};
        check_log("t2", 4);

        // Ready toggling 1,0,0,1 during replay
        do_reset;
        send_frame(8'd40, 4, 1'b1);
        tick;
        OUT_READY = 1'b1;
        tick;
        OUT_READY = 1'b0;
        @(negedge CLK);
        check("t3_stall_a", OUT_DATA, 41);
        tick;
        @(negedge CLK);
        check("t3_stall_b", OUT_DATA, 41);
        tick;
        OUT_READY = 1'b1;
        wait_idle("t3");
        ref_q = '{8'd40, 8'd41, 8'd42, 8'd43};
        check_log("t3", 4);
        check("t3_no_ovf", OVERFLOW, 0);

        // Short frame, then a frame that never sees LAST_PIX
        do_reset;
        send_frame(8'd50, 3, 1'b1);
        wait_idle("t4a");
        check("t4_ferr", FRAME_ERR, 1);
        ref_q = '{8'd50, 8'd51, 8'd52};
        check_log("t4a", 3);
        send_frame(8'd60, 4, 1'b0);
        wait_idle("t4b");
        ref_q = '{8'd60, 8'd61, 8'd62, 8'd63};
        check_log("t4b", 4);

        // Signed values through the write path
        do_reset;
        send(8'hF0, 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b1);
        send(8'h80, 1'b0, 1'b0);
        send(8'h7F, 1'b1, 1'b1);
        wait_idle("t5");
`ifdef POOL_BUF_RELU_EN
        ref_q = '{8'h00, 8'h05, 8'h00, 8'h7F};
`else
        ref_q = '{8'hF0, 8'h05, 8'h80, 8'h7F};
`endif
        check_log("t5", 4);

        // Reset in the middle of a replay
        do_reset;
        send_frame(8'd70, 4, 1'b1);
        tick;
        tick;
        d0 = drain_cnt;
        do_reset;
        @(negedge CLK);
        check("t6_valid", OUT_VALID, 0);
        check("t6_data", OUT_DATA, 0);
        check("t6_lil", OUT_LAST_IN_LINE, 0);
        check("t6_lp", OUT_LAST_PIX, 0);
        check("t6_drain", DRAIN_DONE, 0);
        tick;
        tick;
        tick;
        check("t6_no_pulse", drain_cnt - d0, 0);
        send_frame(8'd80, 4, 1'b1);
        wait_idle("t6");
        ref_q = '{8'd80, 8'd81, 8'd82, 8'd83};
        check_log("t6", 4);
        check("t6_drain_cnt", drain_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
